// File: rtl/sev_seg_scan_controller.sv
// Four-digit seven-segment scan controller.
// Cycles one shared segment bus across four digit selects, blanking the
// first BLANK_CYCLES of every slot to suppress ghosting.
// Optional PWM brightness: define SEV_SEG_SCAN_BRIGHTNESS_EN.
module sev_seg_scan_controller #(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 800,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
  input  logic [3:0] brightness,
  output logic [6:0] seg_out,
  output logic       dot_out,
  output logic [3:0] digit_sel,
  output logic       frame_tick
);

  localparam int unsigned CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WIN       = PRESCALE - BLANK_CYCLES;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_snap_q, seg_snap_d;
  logic            dot_snap_q, dot_snap_d;
  logic            tick_d;
  logic [6:0]      digits [4];
  logic [31:0]     on_len;
  logic [31:0]     win_pos;
  logic            active;
  logic [3:0]      sel_onehot;

`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]      bri_q, bri_d;
`else
  logic            unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  assign digits[0] = digit_0;
  assign digits[1] = digit_1;
  assign digits[2] = digit_2;
  assign digits[3] = digit_3;

  // Next-state: slot counter, digit index and snapshot capture at slot start.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    seg_snap_d = seg_snap_q;
    dot_snap_d = dot_snap_q;
    tick_d     = 1'b0;
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
    bri_d      = bri_q;
`endif
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d    = SCAN;
      cnt_d      = '0;
      idx_d      = '0;
      seg_snap_d = digits[0];
      dot_snap_d = dots[0];
      tick_d     = 1'b1;
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
      bri_d      = brightness;
`endif
    end else if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      idx_d      = idx_q + 2'd1;
      seg_snap_d = digits[idx_d];
      dot_snap_d = dots[idx_d];
      if (idx_d == 2'd0) begin
        tick_d = 1'b1;
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
        bri_d  = brightness;
`endif
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Display window evaluated on next-state values so outputs align with cnt/idx.
  always_comb begin
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
    on_len = (WIN / 16) * (32'(bri_d) + 32'd1);
`else
    on_len = WIN;
`endif
    win_pos    = 32'(cnt_d) - BLANK_CYCLES;
    active     = (state_d == SCAN) && (cnt_d >= CNT_BLANK) && (win_pos < on_len);
    sel_onehot = 4'b0001 << idx_d;
  end

  // State, snapshot and registered output update; reset blanks everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_snap_q <= '0;
      dot_snap_q <= 1'b0;
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
      bri_q      <= '0;
`endif
      seg_out    <= {7{ACTIVE_LOW}};
      dot_out    <= ACTIVE_LOW;
      digit_sel  <= {4{ACTIVE_LOW}};
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_snap_q <= seg_snap_d;
      dot_snap_q <= dot_snap_d;
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
      bri_q      <= bri_d;
`endif
      seg_out    <= {7{ACTIVE_LOW}} ^ (active ? seg_snap_d : 7'h00);
      dot_out    <= ACTIVE_LOW ^ (active & dot_snap_d);
      digit_sel  <= {4{ACTIVE_LOW}} ^ (active ? sel_onehot : 4'h0);
      frame_tick <= tick_d;
    end
  end

endmodule

// File: doc/sev_seg_scan_controller.md
# sev_seg_scan_controller

Time-multiplexing scan controller for a 4-digit common-select seven-segment display. It takes the four decoded segment patterns and dot bits produced by the seven-segment bus interface and drives one shared segment bus plus four digit-select lines, cycling through the digits at a fixed per-digit slot rate. Each slot includes a guard blanking interval against ghosting and, optionally, PWM brightness control. It sits between the display register block and the board pins.

## Interface
Parameters:
- PRESCALE, 50000: clock cycles per digit slot (1 ms at 50 MHz); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 800: blanked cycles at the start of every slot; must be ≥1.
- ACTIVE_LOW, 1: when 1, seg_out, dot_out and digit_sel are active-low; when 0, active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  scan enable; low forces IDLE.
- digit_0..digit_3  in  7 each  segment patterns, bit i = segment i lit.
- dots  in  4  dot bit per digit, bit n = digit n.
- brightness  in  4  0 = dimmest, 15 = full on-window.
- seg_out  out  7  shared segment lines.
- dot_out  out  1  shared dot line.
- digit_sel  out  4  one-hot digit select; all inactive when blanked.
- frame_tick  out  1  one-cycle pulse at the start of each frame (digit 0 slot).

## Operation
- States: IDLE and SCAN. Internal state: cnt (0..PRESCALE-1), idx (0..3), snapshot registers for segments, dot, and brightness.
- Reset (rst=0 at an edge): enter IDLE, cnt=0, idx=0, snapshots cleared.
- All outputs are inactive in IDLE and on reset: seg_out=7'h7F, dot_out=1, digit_sel=4'hF when ACTIVE_LOW=1; all zeros when ACTIVE_LOW=0. frame_tick=0.
- IDLE → SCAN on the first edge with en=1. That edge sets cnt=0 and idx=0, snapshots digit_0, dots[0] and brightness, and asserts frame_tick.
- In SCAN with en=1:
  - cnt increments on each edge.
  - When cnt=PRESCALE-1, the edge sets cnt=0 and idx=(idx+1) mod 4, and snapshots digit_idx and dots[idx] for the new idx.
  - When the new idx is 0, the same edge also snapshots brightness and asserts frame_tick.
- SCAN → IDLE on any edge with en=0. Outputs go inactive and cnt and idx clear on that same edge.
- Window within a slot, with W = PRESCALE-BLANK_CYCLES and on_len defined under Configuration:
  - Active when cnt ≥ BLANK_CYCLES and cnt-BLANK_CYCLES < on_len.
  - When active, digit_sel asserts bit idx, and seg_out and dot_out present the snapshot (polarity per ACTIVE_LOW).
  - Otherwise all outputs are inactive, so segment lines never change while a digit is selected.
- Scan order is digit 0, 1, 2, 3, wrapping to 0. A frame lasts 4·PRESCALE cycles.
- Input changes have no effect on a slot already in progress. Brightness changes take effect at the next frame_tick only.

## Timing
- All outputs are registered and computed from next-state values, so outputs in a cycle match that cycle's cnt and idx with zero lag.
- The first cycle after IDLE→SCAN has cnt=0, which is always blanked.
- Inputs are sampled only on snapshot edges and need no handshake.
- rst has priority over en. A reset mid-slot blanks the outputs at that edge, and no partial slot resumes.

## Configuration
- SEV_SEG_SCAN_BRIGHTNESS_EN defined:
  - on_len = (W/16)·(brightness_snapshot+1).
  - W must be a multiple of 16.
  - brightness=15 gives on_len=W.
- SEV_SEG_SCAN_BRIGHTNESS_EN undefined:
  - on_len = W; the brightness input is ignored and its snapshot register is removed.
  - The port stays in the port list.
  - There is no divisibility constraint on W.

## Test plan
(Benches use PRESCALE=40, BLANK_CYCLES=8, ACTIVE_LOW=1, SEV_SEG_SCAN_BRIGHTNESS_EN defined unless stated.)
- Reset: rst=0 for 3 cycles with en=1 → seg_out=7'h7F, dot_out=1, digit_sel=4'hF, frame_tick=0. On the first edge after rst=1 → frame_tick=1, cnt=0 (outputs still blanked).
- Scan order, brightness=15, digits 7'h01/02/04/08, dots=4'b0101:
  - In slot n, cnt 0..7 blanked; cnt 8..39 gives digit_sel=~(1<<n), seg_out=~digit_n, dot_out=~dots[n].
  - frame_tick fires every 160 cycles.
- Brightness=3 → on-window is cnt 8..15 (8 cycles) and cnt 16..39 is blanked. Changing brightness to 15 in slot 2 takes effect only after the next frame_tick.
- Snapshot: change digit_1 from 7'h3F to 7'h06 at cnt=20 of slot 1 → seg_out holds ~7'h3F through cnt=39. The next slot 1 shows ~7'h06.
- Enable: drop en at cnt=12 of slot 2 → all outputs inactive on that edge. Re-raise en → restart at digit 0 with frame_tick=1 and cnt 0..7 blanked. rst=0 mid-slot behaves identically.
- Macro undefined: brightness=0 → on-window is the full cnt 8..39 in every slot.
